mem2_wb_stage: RTL
==================

Name: mem2_wb_stage

Overview:
- Last memory stage plus the WB pipeline register.
- Consumes the MEM2 pipeline-register outputs and the data-cache response.
- For loads: waits for and buffers the cache read data, aligns it, sign/zero-extends it, and merges it for LWL/LWR.
- Selects the final write-back value, registers it into WB, and raises a load stall to the hazard unit while a load's data is outstanding.

Parameters:
- WB_ALU, 2'b00, WbSel code: result is ALUOut
- WB_LOAD, 2'b01, WbSel code: result is aligned load data
- WB_PC8, 2'b10, WbSel code: result is PC+8 (link)
- WB_OUTB, 2'b11, WbSel code: result is OutB (moved CP0/HI/LO value)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- MEM2_ALUOut  in  32  effective address or ALU result
- MEM2_PC  in  32  instruction PC
- MEM2_Instr  in  32  instruction word; opcode [31:26] selects load type
- MEM2_WbSel  in  2  write-back source select
- MEM2_Dst  in  5  destination register
- MEM2_OutB  in  32  old rt value (LWL/LWR merge) or moved value
- MEM2_RegsWrType  in  RegsWrType  final write enables
- MEM2_LoadReq  in  1  a dcache read for this instruction was issued in MEM
- MEM2_Flush  in  1  kill the MEM2 instruction
- WB_Wr  in  1  WB register write enable (0 = downstream hold)
- dcache_data_ok  in  1  read-data valid pulse
- dcache_rdata  in  32  read data, word aligned
- MEM2_LoadStall  out  1  request to freeze MEM2 and everything upstream
- WB_Result  out  32  write-back value
- WB_PC  out  32  WB-stage PC
- WB_Instr  out  32  WB-stage instruction
- WB_Dst  out  5  WB destination register
- WB_RegsWrType  out  RegsWrType  WB write enables

Behaviour:
- Reset (rst=1 at posedge): FSM to IDLE, data buffer cleared, all WB_* outputs 0, WB_RegsWrType='0. MEM2_LoadStall=0 in the cycle after reset.
- load_pend = MEM2_LoadReq & (MEM2_WbSel==WB_LOAD) & !MEM2_Flush.
- FSM states:
  - IDLE
    - load_pend & data_ok: data used the same cycle, no stall. If WB_Wr=0 the data is stored to the buffer and the FSM goes to HOLD.
    - load_pend & !data_ok: go to WAIT, stall asserted combinationally this cycle.
    - otherwise: stay IDLE.
  - WAIT: stall=1.
    - data_ok & WB_Wr: data used, go to IDLE, stall=0 that cycle.
    - data_ok & !WB_Wr: buffer data, go to HOLD.
    - MEM2_Flush & !data_ok: go to DRAIN.
    - MEM2_Flush & data_ok: data discarded, go to IDLE.
  - HOLD: stall=0. Load data comes from the buffer. On WB_Wr=1 the result is written and the FSM goes to IDLE. Flush goes to IDLE and discards the buffer.
  - DRAIN: stall=1. The next data_ok is discarded and the FSM goes to IDLE. Flush is ignored in this state.
- Alignment, with a = ALUOut[1:0] and little-endian byte lanes:
  - LB/LBU: byte a of rdata, sign- or zero-extended.
  - LH/LHU: half a[1], sign- or zero-extended.
  - LW: rdata unchanged.
  - LWL: top (a+1) bytes taken from the low bytes of rdata; remaining low bytes from OutB.
  - LWR: low (4-a) bytes taken from the high bytes of rdata; remaining high bytes from OutB.
  - Misaligned LH/LW never reach this stage (excepted in MEM); the value produced for them is don't-care.
- Result mux follows WbSel: WB_PC8 = MEM2_PC + 32'd8, with the carry dropped.
- WB register:
  - When WB_Wr=1 and MEM2_LoadStall=0: capture MEM2_* and the result.
  - When WB_Wr=1 and MEM2_LoadStall=1: insert a bubble (WB_RegsWrType='0, other WB fields 0).
  - When WB_Wr=0: hold all WB fields.
  - When MEM2_Flush=1 and WB_Wr=1: insert a bubble.
- Latency: MEM2 to WB is 1 cycle when data is ready; a load waiting N cycles for data delays it by N.

Decomposition:
- Shared package (CPU_Defines) holds:
  - RegsWrType
  - the WbSel constants
  - load opcode localparams: LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110
  - the FSM state enum {IDLE, WAIT, HOLD, DRAIN}
- One sub-module, load_align: purely combinational (rdata, Instr opcode, a, OutB) to 32-bit loaded value; reused by the Test Plan.

Test Plan:
- LW, rdata=32'h8899AABB, data_ok same cycle as issue -> no stall, next cycle WB_Result=8899AABB, WB_Dst=rt.
- LB, a=2, rdata=32'h0080_0000, data_ok 3 cycles late -> MEM2_LoadStall=1 for 3 cycles, WB bubbles in those cycles, then WB_Result=FFFFFF80. LBU gives 00000080.
- LWL, a=1, rdata=11223344, OutB=AABBCCDD -> WB_Result=3344CCDD. LWR, a=1, same data -> AA112233.
- Flush during WAIT, data_ok 2 cycles later -> DRAIN: stall stays 1 until data_ok, that data is dropped, WB_RegsWrType stays '0, FSM back to IDLE.
- data_ok while WB_Wr=0 -> HOLD. Change dcache_rdata afterwards, release WB_Wr -> WB_Result equals the buffered value.
- JAL with PC=32'hBFC00000 (WB_PC8) -> WB_Result=BFC00008. rst asserted mid-WAIT -> IDLE, stall=0, all WB outputs 0.

Source files
------------

// File: rtl/mem2_wb_stage_pkg.sv
// Shared types and constants for the MEM2 -> WB stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem2_wb_stage_pkg;

  // Final register-file / HI / LO write enables carried down the pipe.
  typedef struct packed {
    logic HIWr;
    logic LOWr;
    logic RFWr;
  } RegsWrType;

  // Write-back source select codes.
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC8  = 2'b10;
  localparam logic [1:0] WB_OUTB = 2'b11;

  // Load opcodes (Instr[31:26]).
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LWL = 6'b100010;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] LWR = 6'b100110;

  // Load-data tracking FSM.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD,
    DRAIN
  } load_state_t;

  // Extend a byte to 32 bits, sign-extending when sgn is set.
  function automatic logic [31:0] extend8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  // Extend a halfword to 32 bits, sign-extending when sgn is set.
  function automatic logic [31:0] extend16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem2_wb_stage_if.sv
// MEM2-side inputs, dcache response and WB-side outputs of the MEM2/WB stage.
// Latency: n/a (wiring only).
// Backpressure: WB_Wr=0 holds WB; MEM2_LoadStall freezes MEM2 and upstream.
interface mem2_wb_stage_if;
  import mem2_wb_stage_pkg::*;

  logic [31:0] MEM2_ALUOut;
  logic [31:0] MEM2_PC;
  logic [31:0] MEM2_Instr;
  logic [1:0]  MEM2_WbSel;
  logic [4:0]  MEM2_Dst;
  logic [31:0] MEM2_OutB;
  RegsWrType   MEM2_RegsWrType;
  logic        MEM2_LoadReq;
  logic        MEM2_Flush;
  logic        WB_Wr;
  logic        dcache_data_ok;
  logic [31:0] dcache_rdata;

  logic        MEM2_LoadStall;
  logic [31:0] WB_Result;
  logic [31:0] WB_PC;
  logic [31:0] WB_Instr;
  logic [4:0]  WB_Dst;
  RegsWrType   WB_RegsWrType;

  // Upstream pipeline / cache side drives the MEM2 fields and reads WB.
  modport master (
    output MEM2_ALUOut, MEM2_PC, MEM2_Instr, MEM2_WbSel, MEM2_Dst, MEM2_OutB,
    output MEM2_RegsWrType, MEM2_LoadReq, MEM2_Flush, WB_Wr,
    output dcache_data_ok, dcache_rdata,
    input  MEM2_LoadStall, WB_Result, WB_PC, WB_Instr, WB_Dst, WB_RegsWrType
  );

  // The stage itself.
  modport slave (
    input  MEM2_ALUOut, MEM2_PC, MEM2_Instr, MEM2_WbSel, MEM2_Dst, MEM2_OutB,
    input  MEM2_RegsWrType, MEM2_LoadReq, MEM2_Flush, WB_Wr,
    input  dcache_data_ok, dcache_rdata,
    output MEM2_LoadStall, WB_Result, WB_PC, WB_Instr, WB_Dst, WB_RegsWrType
  );

endinterface

// File: rtl/mem2_wb_stage_load_align.sv
// Aligns word-aligned cache read data per load type; extends and merges LWL/LWR.
// Latency: combinational.
// Backpressure: none.
module mem2_wb_stage_load_align (
  input  logic [31:0] i_rdata,
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_outb,
  output logic [31:0] o_data
);
  import mem2_wb_stage_pkg::*;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_lwl;
  logic [31:0] w_lwr;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // LWL: the low (a+1) bytes of the word land in the top of the register.
  always_comb begin
    w_lwl = i_rdata;
    case (i_addr_lo)
      2'd0:    w_lwl = {i_rdata[7:0],  i_outb[23:0]};
      2'd1:    w_lwl = {i_rdata[15:0], i_outb[15:0]};
      2'd2:    w_lwl = {i_rdata[23:0], i_outb[7:0]};
      default: w_lwl = i_rdata;
    endcase
  end

  // LWR: the high (4-a) bytes of the word land in the bottom of the register.
  always_comb begin
    w_lwr = i_rdata;
    case (i_addr_lo)
      2'd0:    w_lwr = i_rdata;
      2'd1:    w_lwr = {i_outb[31:24], i_rdata[31:8]};
      2'd2:    w_lwr = {i_outb[31:16], i_rdata[31:16]};
      default: w_lwr = {i_outb[31:8],  i_rdata[31:24]};
    endcase
  end

  // Pick the aligned value for the decoded load type.
  always_comb begin
    o_data = i_rdata;
    case (i_op)
      LB:      o_data = extend8(w_byte, 1'b1);
      LBU:     o_data = extend8(w_byte, 1'b0);
      LH:      o_data = extend16(w_half, 1'b1);
      LHU:     o_data = extend16(w_half, 1'b0);
      LWL:     o_data = w_lwl;
      LWR:     o_data = w_lwr;
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem2_wb_stage.sv
// Last memory stage: waits for/buffers dcache load data, selects the result, registers WB.
// Latency: 1 cycle MEM2->WB when data is ready; +N cycles while load data is outstanding.
// Backpressure: WB_Wr=0 holds WB (early load data is buffered); MEM2_LoadStall freezes upstream.
module mem2_wb_stage (
  input  logic     clk,
  input  logic     rst,
  mem2_wb_stage_if.slave bus
);
  import mem2_wb_stage_pkg::*;

  load_state_t r_state;
  load_state_t w_state_nxt;
  logic [31:0] r_buf;

  logic        w_load_pend;
  logic        w_stall;
  logic        w_buf_we;
  logic        w_use_buf;
  logic [31:0] w_raw;
  logic [31:0] w_load_data;
  logic [31:0] w_result;

  logic [31:0] r_wb_result;
  logic [31:0] r_wb_pc;
  logic [31:0] r_wb_instr;
  logic [4:0]  r_wb_dst;
  RegsWrType   r_wb_regs_wr;

  assign w_load_pend = bus.MEM2_LoadReq & (bus.MEM2_WbSel == WB_LOAD) & ~bus.MEM2_Flush;

  // State register for the load-data tracker.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, stall request and buffer control.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_buf_we    = 1'b0;
    w_use_buf   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_load_pend) begin
          if (bus.dcache_data_ok) begin
            // Data is used directly unless WB is held; then park it.
            if (!bus.WB_Wr) begin
              w_buf_we    = 1'b1;
              w_state_nxt = HOLD;
            end
          end else begin
            w_stall     = 1'b1;
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        w_stall = 1'b1;
        if (bus.dcache_data_ok) begin
          w_stall = 1'b0;
          if (bus.MEM2_Flush || bus.WB_Wr) begin
            // Flushed: data dropped. Otherwise: data consumed this cycle.
            w_state_nxt = IDLE;
          end else begin
            w_buf_we    = 1'b1;
            w_state_nxt = HOLD;
          end
        end else if (bus.MEM2_Flush) begin
          // The cache will still answer; that response must be swallowed.
          w_state_nxt = DRAIN;
        end
      end
      HOLD: begin
        w_use_buf = 1'b1;
        if (bus.MEM2_Flush || bus.WB_Wr) w_state_nxt = IDLE;
      end
      DRAIN: begin
        // Stall through the response cycle so no new access overlaps it.
        w_stall = 1'b1;
        if (bus.dcache_data_ok) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Buffer for load data that arrived while WB was held.
  always_ff @(posedge clk) begin
    if (rst)           r_buf <= '0;
    else if (w_buf_we) r_buf <= bus.dcache_rdata;
  end

  assign w_raw = w_use_buf ? r_buf : bus.dcache_rdata;

  mem2_wb_stage_load_align u_align (
    .i_rdata   (w_raw),
    .i_op      (bus.MEM2_Instr[31:26]),
    .i_addr_lo (bus.MEM2_ALUOut[1:0]),
    .i_outb    (bus.MEM2_OutB),
    .o_data    (w_load_data)
  );

  // Final write-back value; PC+8 wraps silently.
  always_comb begin
    w_result = bus.MEM2_ALUOut;
    case (bus.MEM2_WbSel)
      WB_ALU:  w_result = bus.MEM2_ALUOut;
      WB_LOAD: w_result = w_load_data;
      WB_PC8:  w_result = bus.MEM2_PC + 32'd8;
      default: w_result = bus.MEM2_OutB;
    endcase
  end

  // WB pipeline register: capture, bubble on stall/flush, or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_result  <= '0;
      r_wb_pc      <= '0;
      r_wb_instr   <= '0;
      r_wb_dst     <= '0;
      r_wb_regs_wr <= '0;
    end else if (bus.WB_Wr) begin
      if (w_stall || bus.MEM2_Flush) begin
        r_wb_result  <= '0;
        r_wb_pc      <= '0;
        r_wb_instr   <= '0;
        r_wb_dst     <= '0;
        r_wb_regs_wr <= '0;
      end else begin
        r_wb_result  <= w_result;
        r_wb_pc      <= bus.MEM2_PC;
        r_wb_instr   <= bus.MEM2_Instr;
        r_wb_dst     <= bus.MEM2_Dst;
        r_wb_regs_wr <= bus.MEM2_RegsWrType;
      end
    end
  end

  assign bus.MEM2_LoadStall = w_stall;
  assign bus.WB_Result      = r_wb_result;
  assign bus.WB_PC          = r_wb_pc;
  assign bus.WB_Instr       = r_wb_instr;
  assign bus.WB_Dst         = r_wb_dst;
  assign bus.WB_RegsWrType  = r_wb_regs_wr;

endmodule
